// File: rtl/tx_pkt_gen_250_pkg.sv
// pkt_gen_pkg: shared types, protocol constants and frame offsets for the UDP/IPv4 generator
package pkt_gen_pkg;
  localparam int DATA_WIDTH = 512;
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0] IP_PROTO_UDP = 8'd17;
  localparam int MIN_LEN = 60;
  localparam int MAX_LEN = 1514;
  localparam int HDR_BYTES = 42;
  localparam int OFF_ETHERTYPE = 12;
  localparam int OFF_IP_LEN = 16;
  localparam int OFF_IP_ID = 18;
  localparam int OFF_IP_CSUM = 24;
  localparam int OFF_UDP_LEN = 38;
  typedef enum logic [1:0] {IDLE, CALC, SEND, GAP} state_t;
  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [31:0] ip_src;
    logic [31:0] ip_dst;
    logic [31:0] pkt_count;
    logic [15:0] l4_src;
    logic [15:0] l4_dst;
    logic [15:0] tuser_src;
    logic [15:0] tuser_dst;
    logic [15:0] gap;
    logic [10:0] len;
  } cfg_t;
  function automatic logic [10:0] clamp_len(input logic [15:0] l);
    return l < 16'(MIN_LEN) ? 11'(MIN_LEN) : l > 16'(MAX_LEN) ? 11'(MAX_LEN) : l[10:0];
  endfunction
endpackage

// File: rtl/tx_pkt_gen_250_if.sv
// tx_pkt_gen_250_if: 512-bit AXIS stream with size/src/dst tuser sidebands
interface tx_pkt_gen_250_if;
  import pkt_gen_pkg::*;
  logic tvalid;
  logic tready;
  logic tlast;
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic [15:0] tuser_size;
  logic [15:0] tuser_src;
  logic [15:0] tuser_dst;
  modport master(output tvalid, tdata, tkeep, tlast, tuser_size, tuser_src, tuser_dst, input tready);
  modport slave(input tvalid, tdata, tkeep, tlast, tuser_size, tuser_src, tuser_dst, output tready);
endinterface

// File: rtl/tx_pkt_gen_250_csum.sv
// ipv4_csum: combinational 20-byte IPv4 header checksum with end-around carry fold
module ipv4_csum (
  input  logic [159:0] hdr,
  output logic [15:0]  csum
);
  logic [19:0] sum;
  logic [16:0] fold;
  always_comb begin
    sum = '0;
    for (int i = 0; i < 10; i++) sum = sum + 20'(hdr[16*i +: 16]);
    fold = 17'(sum[15:0]) + 17'(sum[19:16]);
    csum = ~(fold[15:0] + 16'(fold[16]));
  end
endmodule

// File: rtl/tx_pkt_gen_250.sv
// tx_pkt_gen_250: UDP/IPv4 frame generator on 512-bit AXIS; TX_PKT_GEN_CHECKSUM_EN enables the IPv4 header checksum
module tx_pkt_gen_250
  import pkt_gen_pkg::*;
(
  input  logic                    axis_aclk,
  input  logic                    box_rst,
  input  logic                    cfg_start,
  input  logic                    cfg_stop,
  input  logic [31:0]             cfg_pkt_count,
  input  logic [15:0]             cfg_pkt_len,
  input  logic [15:0]             cfg_gap,
  input  logic [47:0]             cfg_dst_mac,
  input  logic [47:0]             cfg_src_mac,
  input  logic [31:0]             cfg_ip_src,
  input  logic [31:0]             cfg_ip_dst,
  input  logic [15:0]             cfg_l4_src,
  input  logic [15:0]             cfg_l4_dst,
  input  logic [15:0]             cfg_tuser_src,
  input  logic [15:0]             cfg_tuser_dst,
  tx_pkt_gen_250_if.master        m_axis,
  output logic                    busy,
  output logic [31:0]             sent_cnt
);
`ifdef TX_PKT_GEN_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  state_t state;
  cfg_t c;
  logic [15:0] seq, gap_cnt, csum_w, hdr_csum, tot_len, udp_len;
  logic [4:0] beat, bsel, last_beat;
  logic [6:0] rem;
  logic stop_pending, stop_now, done_w, load;
  logic [159:0] ip_hdr;
  logic [HDR_BYTES*8-1:0] hdr_be;
  logic [DATA_WIDTH-1:0] beat_data;
  logic [KEEP_WIDTH-1:0] last_keep;
  assign busy = state != IDLE;
  assign tot_len = 16'(c.len) - 16'd14;
  assign udp_len = 16'(c.len) - 16'd34;
  assign last_beat = 5'((c.len - 11'd1) >> 6);
  assign rem = {c.len[5:0] == 6'd0, c.len[5:0]};
  assign last_keep = {KEEP_WIDTH{1'b1}} >> (7'd64 - rem);
  assign bsel = state == CALC ? 5'd0 : beat;
  assign stop_now = stop_pending || cfg_stop;
  assign done_w = stop_now || (c.pkt_count != 32'd0 && sent_cnt + 32'd1 == c.pkt_count);
  assign load = state == CALC || (state == SEND && m_axis.tvalid && m_axis.tready && !m_axis.tlast);
  assign ip_hdr = {16'h4500, tot_len, seq, 16'h4000, 8'd64, IP_PROTO_UDP, 16'h0, c.ip_src, c.ip_dst};
  ipv4_csum u_csum (.hdr(ip_hdr), .csum(csum_w));
  // the checksum is captured straight into the beat-0 tdata register at the end of CALC
  assign hdr_csum = CSUM_EN ? csum_w : 16'h0;
  assign hdr_be = {c.dst_mac, c.src_mac, ETHERTYPE_IPV4, ip_hdr[159:80], hdr_csum, ip_hdr[63:0],
                   c.l4_src, c.l4_dst, udp_len, 16'h0};
  always_comb begin
    for (int j = 0; j < KEEP_WIDTH; j++) beat_data[8*j +: 8] = {bsel[1:0], 6'(j)};
    if (bsel == 5'd0)
      for (int i = 0; i < HDR_BYTES; i++) beat_data[8*i +: 8] = hdr_be[8*(HDR_BYTES-1-i) +: 8];
  end
  always_ff @(posedge axis_aclk)
    if (state == IDLE && cfg_start)
      c <= '{dst_mac: cfg_dst_mac, src_mac: cfg_src_mac, ip_src: cfg_ip_src, ip_dst: cfg_ip_dst,
             pkt_count: cfg_pkt_count, l4_src: cfg_l4_src, l4_dst: cfg_l4_dst,
             tuser_src: cfg_tuser_src, tuser_dst: cfg_tuser_dst, gap: cfg_gap,
             len: clamp_len(cfg_pkt_len)};
  always_ff @(posedge axis_aclk) begin
    if (box_rst) begin
      state <= IDLE;
      stop_pending <= 1'b0;
      sent_cnt <= '0;
      seq <= '0;
      beat <= '0;
      gap_cnt <= '0;
      m_axis.tvalid <= 1'b0;
      m_axis.tdata <= '0;
      m_axis.tkeep <= '0;
      m_axis.tlast <= 1'b0;
      m_axis.tuser_size <= '0;
      m_axis.tuser_src <= '0;
      m_axis.tuser_dst <= '0;
    end else begin
      if (state != IDLE && cfg_stop) stop_pending <= 1'b1;
      case (state)
        IDLE: begin
          stop_pending <= 1'b0;
          if (cfg_start) begin
            state <= CALC;
            sent_cnt <= '0;
            seq <= '0;
          end
        end
        CALC: state <= SEND;
        SEND: if (m_axis.tvalid && m_axis.tready && m_axis.tlast) begin
          m_axis.tvalid <= 1'b0;
          m_axis.tlast <= 1'b0;
          sent_cnt <= sent_cnt + 32'd1;
          seq <= seq + 16'd1;
          gap_cnt <= c.gap;
          state <= done_w ? IDLE : c.gap == 16'd0 ? CALC : GAP;
        end
        GAP: begin
          gap_cnt <= gap_cnt - 16'd1;
          state <= stop_now ? IDLE : gap_cnt == 16'd1 ? CALC : GAP;
        end
        default: state <= IDLE;
      endcase
      if (load) begin
        m_axis.tvalid <= 1'b1;
        m_axis.tdata <= beat_data;
        m_axis.tkeep <= bsel == last_beat ? last_keep : {KEEP_WIDTH{1'b1}};
        m_axis.tlast <= bsel == last_beat;
        m_axis.tuser_size <= 16'(c.len);
        m_axis.tuser_src <= c.tuser_src;
        m_axis.tuser_dst <= c.tuser_dst;
        beat <= bsel + 5'd1;
      end
    end
  end
endmodule

// File: tb/tb_tx_pkt_gen_250.sv
// tb_tx_pkt_gen_250: directed self-checking bench for the UDP/IPv4 frame generator
module tb_tx_pkt_gen_250;
  import pkt_gen_pkg::*;
  typedef struct packed {
    logic [511:0] d;
    logic [63:0]  k;
    logic         l;
    logic [15:0]  sz;
  } beat_t;
`ifdef TX_PKT_GEN_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
  logic [31:0] count = '0;
  logic [15:0] len = '0, gap = '0;
  logic busy;
  logic [31:0] sent;
  int total = 0, bad = 0;
  beat_t cap[$], ref_q[$];
  int idles[$];
  bit seen;
  tx_pkt_gen_250_if m_axis();
  tx_pkt_gen_250 dut (
    .axis_aclk(clk), .box_rst(rst), .cfg_start(start), .cfg_stop(stop),
    .cfg_pkt_count(count), .cfg_pkt_len(len), .cfg_gap(gap),
    .cfg_dst_mac(48'h02_00_00_00_00_02), .cfg_src_mac(48'h02_00_00_00_00_01),
    .cfg_ip_src(32'h0A00_0001), .cfg_ip_dst(32'h0A00_0002),
    .cfg_l4_src(16'd1234), .cfg_l4_dst(16'd5678),
    .cfg_tuser_src(16'h0003), .cfg_tuser_dst(16'h0005),
    .m_axis(m_axis), .busy(busy), .sent_cnt(sent)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [511:0] o, input logic [511:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  function automatic logic [15:0] f16(input logic [511:0] d, input int o);
    return {d[8*o +: 8], d[8*(o+1) +: 8]};
  endfunction
  function automatic logic [7:0] b8(input logic [511:0] d, input int o);
    return d[8*o +: 8];
  endfunction
  function automatic beat_t cur();
    return '{d: m_axis.tdata, k: m_axis.tkeep, l: m_axis.tlast, sz: m_axis.tuser_size};
  endfunction
  task automatic go(input logic [15:0] l, input logic [31:0] n, input logic [15:0] g, input logic s);
    len = l;
    count = n;
    gap = g;
    start = 1'b1;
    stop = s;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
  endtask
  // records accepted beats and idle gaps until the generator drops busy; stalls must hold outputs
  task automatic mon(input bit bp, input int stop_pkt, input int budget);
    beat_t pb = '0;
    logic pv = 1'b0, pr = 1'b1;
    int idle = -1, pkts = 0, nb = 0;
    bit done = 1'b0;
    cap.delete();
    idles.delete();
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      @(negedge clk);
      stop = 1'b0;
      if (pv && !pr) begin
        chk("stall_tvalid", m_axis.tvalid, 1'b1);
        chk("stall_tdata", m_axis.tdata, pb.d);
        chk("stall_ctl", {m_axis.tkeep, m_axis.tlast, m_axis.tuser_size}, {pb.k, pb.l, pb.sz});
      end
      if (m_axis.tvalid && idle >= 0) begin
        idles.push_back(idle);
        idle = -1;
      end else if (!m_axis.tvalid && idle >= 0) idle++;
      if (cap.size() > 0 && !busy) done = 1'b1;
      else begin
        pr = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        m_axis.tready = pr;
        if (m_axis.tvalid && pr) begin
          cap.push_back(cur());
          nb++;
          if (pkts == stop_pkt && nb == 2) stop = 1'b1;
          if (m_axis.tlast) begin
            pkts++;
            nb = 0;
            idle = 0;
          end
        end
        pv = m_axis.tvalid;
        pb = cur();
      end
    end
    chk("mon_done", done, 1'b1);
  endtask
  initial begin
    m_axis.tready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", m_axis.tvalid, 1'b0);
    chk("rst_tlast", m_axis.tlast, 1'b0);
    chk("rst_tdata", m_axis.tdata, '0);
    chk("rst_tkeep", m_axis.tkeep, '0);
    chk("rst_tuser", {m_axis.tuser_size, m_axis.tuser_src, m_axis.tuser_dst}, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sent", sent, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    go(16'd60, 32'd1, 16'd0, 1'b0);
    chk("a_busy_calc", busy, 1'b1);
    chk("a_tvalid_calc", m_axis.tvalid, 1'b0);
    @(negedge clk);
    chk("a_tvalid", m_axis.tvalid, 1'b1);
    chk("a_tkeep", m_axis.tkeep, 64'h0FFF_FFFF_FFFF_FFFF);
    chk("a_tlast", m_axis.tlast, 1'b1);
    chk("a_tuser", {m_axis.tuser_size, m_axis.tuser_src, m_axis.tuser_dst}, {16'd60, 16'h3, 16'h5});
    chk("a_byte0", b8(m_axis.tdata, 0), 8'h02);
    chk("a_ethertype", f16(m_axis.tdata, OFF_ETHERTYPE), 16'h0800);
    chk("a_ip_len", f16(m_axis.tdata, OFF_IP_LEN), 16'h002E);
    chk("a_ip_id", f16(m_axis.tdata, OFF_IP_ID), 16'h0000);
    chk("a_ip_csum", f16(m_axis.tdata, OFF_IP_CSUM), CSUM ? 16'h26BD : 16'h0000);
    chk("a_udp_len", f16(m_axis.tdata, OFF_UDP_LEN), 16'h001A);
    chk("a_pay42", b8(m_axis.tdata, 42), 8'h2A);
    chk("a_pay59", b8(m_axis.tdata, 59), 8'h3B);
    @(negedge clk);
    chk("a_tvalid_end", m_axis.tvalid, 1'b0);
    chk("a_sent", sent, 32'd1);
    chk("a_busy_end", busy, 1'b0);
    go(16'd130, 32'd2, 16'd0, 1'b1);
    len = 16'd999;
    gap = 16'd5;
    mon(1'b0, -1, 200);
    chk("b_beats", cap.size(), 6);
    chk("b_keep_mid", cap[1].k, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("b_keep_last", cap[2].k, 64'h3);
    chk("b_last_flags", {cap[0].l, cap[1].l, cap[2].l, cap[3].l, cap[4].l, cap[5].l}, 6'b001001);
    chk("b_ip_len", f16(cap[0].d, OFF_IP_LEN), 16'h0074);
    chk("b_udp_len", f16(cap[0].d, OFF_UDP_LEN), 16'h0060);
    chk("b_id0", f16(cap[0].d, OFF_IP_ID), 16'h0000);
    chk("b_id1", f16(cap[3].d, OFF_IP_ID), 16'h0001);
    chk("b_csum1", f16(cap[3].d, OFF_IP_CSUM), CSUM ? 16'h2676 : 16'h0000);
    chk("b_pay100", b8(cap[1].d, 36), 8'h64);
    chk("b_size", cap[5].sz, 16'd130);
    chk("b_idle", idles.size() > 0 ? idles[0] : -1, 1);
    chk("b_sent", sent, 32'd2);
    ref_q = cap;
    go(16'd130, 32'd2, 16'd0, 1'b0);
    mon(1'b1, -1, 400);
    chk("c_beats", cap.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("c_data%0d", i), cap[i].d, ref_q[i].d);
      chk($sformatf("c_ctl%0d", i), {cap[i].k, cap[i].l, cap[i].sz}, {ref_q[i].k, ref_q[i].l, ref_q[i].sz});
    end
    chk("c_sent", sent, 32'd2);
    m_axis.tready = 1'b1;
    go(16'd130, 32'd0, 16'd3, 1'b0);
    mon(1'b0, 1, 400);
    chk("d_beats", cap.size(), 6);
    chk("d_idle_n", idles.size(), 1);
    chk("d_idle", idles.size() > 0 ? idles[0] : -1, 4);
    chk("d_sent", sent, 32'd2);
    chk("d_busy", busy, 1'b0);
    go(16'd2000, 32'd1, 16'd0, 1'b0);
    mon(1'b0, -1, 100);
    chk("clamp_hi_beats", cap.size(), 24);
    chk("clamp_hi_keep", cap[23].k, 64'h0000_03FF_FFFF_FFFF);
    chk("clamp_hi_size", cap[23].sz, 16'd1514);
    chk("clamp_hi_iplen", f16(cap[0].d, OFF_IP_LEN), 16'h05DC);
    go(16'd10, 32'd1, 16'd0, 1'b0);
    mon(1'b0, -1, 50);
    chk("clamp_lo_beats", cap.size(), 1);
    chk("clamp_lo", {cap[0].k, cap[0].l, cap[0].sz}, {64'h0FFF_FFFF_FFFF_FFFF, 1'b1, 16'd60});
    m_axis.tready = 1'b1;
    go(16'd130, 32'd1, 16'd0, 1'b0);
    @(negedge clk);
    chk("e_beat0", m_axis.tvalid, 1'b1);
    @(negedge clk);
    chk("e_beat1", {m_axis.tvalid, m_axis.tlast, m_axis.tkeep}, {1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("e_tvalid", m_axis.tvalid, 1'b0);
    chk("e_sent", sent, 32'd0);
    chk("e_busy", busy, 1'b0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (m_axis.tvalid) seen = 1'b1;
    end
    chk("e_no_resume", seen, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tx_pkt_gen_250.md
# tx_pkt_gen_250

Synthetic UDP/IPv4 packet transmitter for the 250 MHz box. It is the transmit-side counterpart of the RX header peek/filter path: the RX path parses Ethernet/IPv4/L4 headers out of a 512-bit AXIS stream, and this block composes those same headers from configuration and drives them onto a 512-bit AXIS master with size/src/dst tuser sidebands. It drives traffic toward the adapter/QDMA for bring-up, loopback and filter-rule testing.

## Interface
- DATA_WIDTH, 512, AXIS data width in bits; only 512 is supported.
- KEEP_WIDTH, 64, tkeep width; equals DATA_WIDTH/8.
- axis_aclk  in  1  250 MHz clock; the block's only clock.
- box_rst  in  1  synchronous, active-high reset.
- cfg_start  in  1  one-cycle pulse; honoured only in IDLE.
- cfg_stop  in  1  one-cycle pulse; requests a stop at the next packet boundary.
- cfg_pkt_count  in  32  number of packets to send; 0 means unlimited.
- cfg_pkt_len  in  16  frame bytes excluding FCS; clamped to 60..1514.
- cfg_gap  in  16  idle cycles between tlast acceptance and the next packet.
- cfg_dst_mac, cfg_src_mac  in  48 each  Ethernet addresses.
- cfg_ip_src, cfg_ip_dst  in  32 each  IPv4 addresses.
- cfg_l4_src, cfg_l4_dst  in  16 each  UDP ports.
- cfg_tuser_src, cfg_tuser_dst  in  16 each  copied to the tuser sidebands.
- m_axis_tvalid / tdata / tkeep / tlast  out  1 / 512 / 64 / 1  AXIS master.
- m_axis_tuser_size / tuser_src / tuser_dst  out  16 each  clamped length, cfg_tuser_src, cfg_tuser_dst.
- m_axis_tready  in  1  downstream ready.
- busy  out  1  high in every state other than IDLE.
- sent_cnt  out  32  packets fully accepted since start; wraps at 2^32.

## Operation
- **FSM states:** IDLE, CALC, SEND, GAP.
- **IDLE → CALC:** on cfg_start, snapshot all cfg_* inputs, clear sent_cnt, and clear the sequence ID.
  - cfg_* changes after the snapshot are ignored until the next start.
- **CALC (1 cycle):** compute the IPv4 header checksum into a register; reset the beat counter; go to SEND.
- **Frame layout:** byte 0 of the frame is at tdata[7:0]; multi-byte fields are in network order.
  - Ethernet: dst, src, ethertype 0x0800.
  - IPv4 header:
    - 0x45, TOS 0, total length = len-14.
    - ID = sequence[15:0], flags/frag 0x4000.
    - TTL 64, protocol 17, checksum.
    - src, dst.
  - UDP: sport, dport, length = len-34, checksum 0.
  - Payload: byte at frame offset i (i ≥ 42) equals i[7:0].
- **Beats:** N = ceil(len/64), range 1..24.
  - All beats except the last have tkeep all ones.
  - The last beat has the low (len-64·(N-1)) tkeep bits set, and tlast = 1.
- **SEND exit:** on acceptance of tlast:
  - increment sent_cnt and the sequence ID;
  - if a stop is pending, or cfg_pkt_count ≠ 0 and sent_cnt+1 == cfg_pkt_count, go to IDLE;
  - otherwise, if gap = 0 go to CALC, else go to GAP.
- **GAP:** count cfg_gap cycles, then go to CALC.
- **Stop handling:**
  - cfg_stop in any non-IDLE state sets stop_pending, cleared on entry to IDLE.
  - A stop never truncates a packet.
  - A stop received during GAP or CALC lets the already-begun CALC/SEND complete one packet only if SEND was entered; from GAP it returns to IDLE immediately.
- **Reset:** all outputs are 0 after reset: tvalid, tlast, tdata, tkeep, tuser_*, busy, sent_cnt.
  - Reset mid-packet abandons the frame; transmission does not resume.

## Timing
- First tvalid is asserted 2 cycles after cfg_start is sampled (IDLE → CALC → SEND).
- At most one beat is transferred per cycle when tvalid & tready.
- **Stall:** while tvalid & !tready, every m_axis_* output holds stable.
  - tvalid never drops once asserted until that beat is accepted.
- **Back-to-back packets with gap = 0:** exactly 1 idle cycle (CALC) between tlast acceptance and the next tvalid.
- **With gap = G:** exactly G+1 idle cycles between tlast acceptance and the next tvalid.
- **Simultaneous cfg_start and cfg_stop in IDLE:** start wins and stop is ignored.
- **cfg_start outside IDLE:** ignored.

## Configuration
- **TX_PKT_GEN_CHECKSUM_EN defined:** the IPv4 checksum is the ones-complement of the ones-complement sum of the header's 16-bit words, computed in CALC.
- **Not defined:** the checksum field is 0x0000. CALC remains, so timing is identical in both builds.

## Structure
- **Package pkt_gen_pkg:**
  - state enum;
  - ETHERTYPE_IPV4, IP_PROTO_UDP;
  - MIN_LEN = 60, MAX_LEN = 1514;
  - header byte offsets;
  - HDR_BYTES = 42.
- **Sub-module ipv4_csum:** combinational 20-byte header checksum with end-around carry fold, registered by the parent in CALC.

## Test plan
- **Single minimum frame:** len=60, count=1, gap=0, tready=1.
  - Required: one beat, tkeep=0x0FFF_FFFF_FFFF_FFFF, tlast=1, tuser_size=60.
  - Then sent_cnt=1 and busy=0.
- **Checksum:** src 10.0.0.1, dst 10.0.0.2, len 60, ID 0.
  - Required: total length 0x002E, checksum 0x26BD.
  - Without the macro, the checksum field is 0x0000.
- **Multi-beat frames:** len=130, count=2.
  - Required per packet: 3 beats, last tkeep=0x3, IP length 0x0074, UDP length 0x0060.
  - IDs are 0 then 1; payload byte at offset 100 is 0x64.
- **Backpressure:** repeat the multi-beat case with random tready.
  - Required: identical accepted beat stream; outputs stable during every stall.
- **Unlimited count with gap and stop:** count=0, gap=3, cfg_stop pulsed mid-packet 2.
  - Required: exactly 2 packets; 4 idle cycles between them; then IDLE.
- **Reset mid-packet:** assert box_rst during beat 2 of a 3-beat frame.
  - Required: tvalid=0 and sent_cnt=0 the next cycle; no further beats without a new cfg_start.
